spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  SPI master: serialises a parallel word onto MOSI and captures MISO, MSB first, all four CPOL/CPHA modes.
//  Generates sclk and ss_n from the system clock through a programmable half-period divider.
//  It is the initiating end for spi_slave; a master's sclk/ss_n/mosi/miso connect 1:1 to spi_slave.
//  Sits between register/PWM control logic and the off-chip or on-chip SPI bus.
// PARAMETERS
//  data_length  16  bits per transfer, >=2
//  clk_div      4   sclk half-period H in clk cycles, >=1 (sclk = clk/(2*clk_div))
// PORTS
//  clk      in   1            system clock, all logic on rising edge
//  reset    in   1            synchronous, active-high reset
//  cpol     in   1            clock polarity (sclk idle level), sampled at start
//  cpha     in   1            clock phase, sampled at start
//  enable   in   1            start request; accepted only in IDLE
//  tx       in   data_length  word to send, latched when enable is accepted
//  rx       out  data_length  last received word, updated at end of transfer
//  busy     out  1            transfer in progress (SETUP..GAP)
//  done     out  1            one-cycle pulse, rx valid
//  sclk     out  1            SPI clock (registered)
//  ss_n     out  1            slave select, active low (registered)
//  mosi     out  1            master out (registered)
//  miso     in   1            master in
// BEHAVIOUR
//  Reset: state=IDLE, sclk=0, ss_n=1, mosi=0, rx=0, busy=0, done=0; shift regs and counters cleared; overrides everything, including mid-transfer.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE. A divider counts H cycles per half-period; an edge counter counts k=1..2N (N=data_length).
//  IDLE: sclk<=cpol each cycle, mosi=0, ss_n=1. enable=1 at cycle 0 -> latch tx/cpol/cpha, go SETUP.
//  Cycle 1: ss_n=0, busy=1, mosi=tx[N-1]. SETUP lasts H cycles.
//  XFER: sclk edge k occurs at cycle 1+k*H. Odd k is the leading edge, even k the trailing edge. After edge 2N, sclk is back at cpol.
//  CPHA=0: sample miso on odd k. Shift mosi to the next bit on even k, k<=2N-2.
//  CPHA=1: sample miso on even k. Shift mosi to the next bit on odd k, k>=3.
//  Sampling captures miso in the same clk cycle the sclk register toggles, i.e. the value present just before the edge. Received bits shift in MSB first.
//  HOLD: H cycles with ss_n=0 and mosi holding the last bit.
//  At cycle 1+(2N+1)*H: ss_n<=1, rx<=received word, done=1 for exactly that cycle, go GAP.
//  GAP: H cycles with ss_n=1, mosi=0. busy drops at cycle 1+(2N+2)*H, state IDLE. This guarantees ss_n high for >=H+1 cycles between transfers.
//  enable while busy: ignored, no queuing. enable held high: back-to-back transfers.
//  cpol/cpha/tx changes during busy: no effect on the current transfer.
//  rx holds its value except at done; a transfer aborted by reset leaves rx=0.
//  No metastability sync on miso: sclk and miso are timed to the same clk domain; the bus budget is clk_div>=2 for off-chip use.
// TESTING
//  Mode0, N=16, H=4, miso tied to mosi, tx=16'hA5C3, enable at cyc0 -> ss_n low cyc1, first edge cyc5, done cyc133, rx=16'hA5C3, busy low cyc137.
//  Modes 1/2/3, spi_slave model returning 16'h3C5A -> rx=16'h3C5A; slave sees 16'hA5C3; sclk idles at cpol before and after.
//  Every mode -> exactly 32 sclk toggles while ss_n=0; mosi changes only on the launch edges defined above.
//  enable pulsed at cyc40 of an active transfer -> ignored; single done; tx change mid-transfer does not alter mosi.
//  reset at cyc50 mid-transfer -> cyc51: ss_n=1, busy=0, done=0, rx=0, mosi=0; a new enable works normally.
//  H=1, enable held high, tx=16'h0001 then 16'h8000 -> two transfers, ss_n high for 2 cycles between, rx sequence matches loopback.

Source files
------------

// File: rtl/spi_if.sv
// SPI master control and bus bundle.
// The master modport is the spi_master's view: control inputs and the
// SPI wires it drives. The slave modport is the opposite side: whoever
// drives the control inputs and supplies miso.
interface spi_if #(
    parameter int data_length = 16
);
    logic                   cpol;
    logic                   cpha;
    logic                   enable;
    logic [data_length-1:0] tx;
    logic [data_length-1:0] rx;
    logic                   busy;
    logic                   done;
    logic                   sclk;
    logic                   ss_n;
    logic                   mosi;
    logic                   miso;

    modport master (
        input  cpol, cpha, enable, tx, miso,
        output rx, busy, done, sclk, ss_n, mosi
    );

    modport slave (
        output cpol, cpha, enable, tx, miso,
        input  rx, busy, done, sclk, ss_n, mosi
    );
endinterface

// File: rtl/spi_master.sv
// SPI master for all four CPOL/CPHA modes. Words are sent and received
// MSB first. sclk is produced by a half-period divider of clk_div cycles.
// Sequence: IDLE -> SETUP -> XFER -> HOLD -> GAP -> IDLE.
// Every SPI output is driven straight from a register.
module spi_master #(
    parameter int data_length = 16,
    parameter int clk_div     = 4
) (
    input  logic  clk,
    input  logic  reset,
    spi_if.master bus
);
    localparam int N     = data_length;
    localparam int DIV_W = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam int EW    = $clog2(2 * N + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [EW-1:0]    edge_cnt;   // sclk edges already generated
    logic [N-1:0]     tx_sh;      // bits still to launch, next bit at the MSB
    logic [N-1:0]     rx_sh;
    logic             cpha_q;
    logic             sclk_q;
    logic             ss_n_q;
    logic             mosi_q;
    logic [N-1:0]     rx_q;
    logic             busy_q;
    logic             done_q;

    logic          half_end;
    logic [EW-1:0] k;
    logic          sample_now;
    logic          shift_now;

    assign half_end = (div_cnt == DIV_W'(clk_div - 1));
    assign k        = edge_cnt + EW'(1);
    // Odd k is the leading edge. CPHA=0 samples on leading edges and
    // launches on trailing ones. CPHA=1 is the reverse. The first bit is
    // already on mosi when ss_n falls, so no launch happens on edge 1 and
    // nothing is shifted after the last sample.
    assign sample_now = k[0] ^ cpha_q;
    assign shift_now  = cpha_q ? (k[0] && (k >= EW'(3)))
                               : (!k[0] && (k <= EW'(2 * N - 2)));

    // Transfer sequencer: divider, edge generation, shifting and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cpha_q   <= 1'b0;
            sclk_q   <= 1'b0;
            ss_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            rx_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_q   <= bus.cpol;
                    mosi_q   <= 1'b0;
                    ss_n_q   <= 1'b1;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (bus.enable) begin
                        cpha_q <= bus.cpha;
                        tx_sh  <= {bus.tx[N-2:0], 1'b0};
                        mosi_q <= bus.tx[N-1];
                        ss_n_q <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP, XFER: begin
                    if (half_end) begin
                        div_cnt  <= '0;
                        sclk_q   <= ~sclk_q;
                        edge_cnt <= k;
                        // miso is read before the sclk register toggles
                        if (sample_now) rx_sh <= {rx_sh[N-2:0], bus.miso};
                        if (shift_now) begin
                            mosi_q <= tx_sh[N-1];
                            tx_sh  <= {tx_sh[N-2:0], 1'b0};
                        end
                        state <= (k == EW'(2 * N)) ? HOLD : XFER;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        ss_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        rx_q    <= rx_sh;
                        done_q  <= 1'b1;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                GAP: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.ss_n = ss_n_q;
    assign bus.mosi = mosi_q;
    assign bus.rx   = rx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master. The H=4 instance runs against either a
// loopback (miso = mosi) or a behavioural SPI slave. The H=1 instance
// runs in loopback for the back-to-back case.
module tb_spi_master;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spi_if #(.data_length(16)) b4();
    spi_if #(.data_length(16)) b1();

    spi_master #(.data_length(16), .clk_div(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    spi_master #(.data_length(16), .clk_div(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    int n_cmp = 0;
    int n_bad = 0;

    // miso source for the H=4 instance
    logic        loop = 1'b1;
    logic        s_miso = 1'b0;
    logic [15:0] slave_word = '0;
    logic [15:0] s_out = '0;
    logic [15:0] s_rx = '0;
    logic        s_act = 1'b0;
    logic        s_psclk = 1'b0;
    assign b4.miso = loop ? b4.mosi : s_miso;
    assign b1.miso = b1.mosi;

    // Behavioural SPI slave: responds with slave_word and collects mosi.
    always @(b4.ss_n or b4.sclk) begin
        if (b4.ss_n === 1'b1) begin
            s_act   = 1'b0;
            s_psclk = b4.sclk;
        end else if (!s_act) begin
            s_act   = 1'b1;
            s_out   = slave_word;
            s_rx    = '0;
            s_psclk = b4.sclk;
            if (!b4.cpha) s_miso = s_out[15];
        end else if (b4.sclk !== s_psclk) begin
            s_psclk = b4.sclk;
            if ((b4.sclk !== b4.cpol) ^ b4.cpha) begin
                s_rx = {s_rx[14:0], b4.mosi};
            end else if (b4.cpha) begin
                s_miso = s_out[15];
                s_out  = {s_out[14:0], 1'b0};
            end else begin
                s_out  = {s_out[14:0], 1'b0};
                s_miso = s_out[15];
            end
        end
    end

    // Running totals of sclk toggles while selected and of mosi changes
    // that do not line up with a launch edge.
    int   toggles = 0;
    int   bad_mosi = 0;
    logic p_sclk = 1'b0;
    logic p_ss = 1'b1;
    logic p_mosi = 1'b0;
    always @(negedge clk) begin
        if (b4.ss_n === 1'b0 && p_ss === 1'b0) begin
            if (b4.sclk !== p_sclk) toggles++;
            if (b4.mosi !== p_mosi &&
                (b4.sclk === p_sclk ||
                 (b4.cpha ? (b4.sclk === b4.cpol) : (b4.sclk !== b4.cpol))))
                bad_mosi++;
        end
        p_sclk = b4.sclk;
        p_ss   = b4.ss_n;
        p_mosi = b4.mosi;
    end

    // One transfer on the H=4 instance, enable seen at cycle 0. Events
    // are reported by cycle number. Optionally re-pulses enable with a
    // different tx at cycle en_at.
    task automatic run_xfer(input logic [15:0] txw, input int ncyc, input int en_at,
                            output int t_ss, output int t_edge, output int t_done,
                            output int t_busy, output int done_cnt,
                            output logic [15:0] rxv);
        logic cp;
        t_ss = -1; t_edge = -1; t_done = -1; t_busy = -1; done_cnt = 0; rxv = 'x;
        @(negedge clk);
        cp = b4.cpol;
        b4.tx = txw;
        b4.enable = 1'b1;
        @(posedge clk);
        #1 b4.enable = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (b4.ss_n === 1'b0 && t_ss < 0) t_ss = c;
            if (b4.sclk !== cp && t_edge < 0) t_edge = c;
            if (b4.done === 1'b1) begin
                done_cnt++;
                t_done = c;
                rxv = b4.rx;
            end
            if (b4.busy === 1'b0 && t_busy < 0) t_busy = c;
            if (c == en_at) begin
                b4.enable = 1'b1;
                b4.tx = ~txw;
            end
            if (c == en_at + 1) b4.enable = 1'b0;
        end
        b4.tx = txw;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b4.cpol = 0; b4.cpha = 0; b4.enable = 0; b4.tx = '0;
        b1.cpol = 0; b1.cpha = 0; b1.enable = 0; b1.tx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (b4.sclk !== 1'b0) begin n_bad++; $display("FAIL reset_sclk got=%b exp=0", b4.sclk); end
        n_cmp++; if (b4.ss_n !== 1'b1) begin n_bad++; $display("FAIL reset_ss_n got=%b exp=1", b4.ss_n); end
        n_cmp++; if (b4.mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi got=%b exp=0", b4.mosi); end
        n_cmp++; if (b4.rx !== 16'h0) begin n_bad++; $display("FAIL reset_rx got=%h exp=0000", b4.rx); end
        n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", b4.busy); end
        n_cmp++; if (b4.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", b4.done); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0_timing();
        int t_ss, t_edge, t_done, t_busy, dc, tg0, bm0;
        logic [15:0] rxv;
        loop = 1'b1;
        tg0 = toggles; bm0 = bad_mosi;
        run_xfer(16'hA5C3, 145, -1, t_ss, t_edge, t_done, t_busy, dc, rxv);
        n_cmp++; if (t_ss != 1) begin n_bad++; $display("FAIL m0_ss_low_cycle got=%0d exp=1", t_ss); end
        n_cmp++; if (t_edge != 5) begin n_bad++; $display("FAIL m0_first_edge_cycle got=%0d exp=5", t_edge); end
        n_cmp++; if (t_done != 133) begin n_bad++; $display("FAIL m0_done_cycle got=%0d exp=133", t_done); end
        n_cmp++; if (t_busy != 137) begin n_bad++; $display("FAIL m0_busy_low_cycle got=%0d exp=137", t_busy); end
        n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL m0_done_count got=%0d exp=1", dc); end
        n_cmp++; if (rxv !== 16'hA5C3) begin n_bad++; $display("FAIL m0_rx got=%h exp=a5c3", rxv); end
        n_cmp++; if (toggles - tg0 != 32) begin n_bad++; $display("FAIL m0_toggles got=%0d exp=32", toggles - tg0); end
        n_cmp++; if (bad_mosi != bm0) begin n_bad++; $display("FAIL m0_mosi_launch got=%0d exp=0", bad_mosi - bm0); end
    endtask

    task automatic test_modes_slave();
        int t_ss, t_edge, t_done, t_busy, dc, tg0, bm0;
        logic [15:0] rxv;
        loop = 1'b0;
        slave_word = 16'h3C5A;
        for (int m = 1; m <= 3; m++) begin
            @(negedge clk);
            b4.cpol = m[1];
            b4.cpha = m[0];
            repeat (3) @(negedge clk);
            n_cmp++; if (b4.sclk !== b4.cpol) begin n_bad++; $display("FAIL mode%0d_idle_before got=%b exp=%b", m, b4.sclk, b4.cpol); end
            tg0 = toggles; bm0 = bad_mosi;
            run_xfer(16'hA5C3, 140, -1, t_ss, t_edge, t_done, t_busy, dc, rxv);
            n_cmp++; if (rxv !== 16'h3C5A) begin n_bad++; $display("FAIL mode%0d_rx got=%h exp=3c5a", m, rxv); end
            n_cmp++; if (s_rx !== 16'hA5C3) begin n_bad++; $display("FAIL mode%0d_slave_rx got=%h exp=a5c3", m, s_rx); end
            n_cmp++; if (toggles - tg0 != 32) begin n_bad++; $display("FAIL mode%0d_toggles got=%0d exp=32", m, toggles - tg0); end
            n_cmp++; if (bad_mosi != bm0) begin n_bad++; $display("FAIL mode%0d_mosi_launch got=%0d exp=0", m, bad_mosi - bm0); end
            n_cmp++; if (b4.sclk !== b4.cpol) begin n_bad++; $display("FAIL mode%0d_idle_after got=%b exp=%b", m, b4.sclk, b4.cpol); end
        end
        @(negedge clk);
        b4.cpol = 0; b4.cpha = 0;
        loop = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable_while_busy();
        int t_ss, t_edge, t_done, t_busy, dc;
        logic [15:0] rxv;
        run_xfer(16'hA5C3, 200, 40, t_ss, t_edge, t_done, t_busy, dc, rxv);
        n_cmp++; if (dc != 1) begin n_bad++; $display("FAIL busy_en_done_count got=%0d exp=1", dc); end
        n_cmp++; if (rxv !== 16'hA5C3) begin n_bad++; $display("FAIL busy_en_rx got=%h exp=a5c3", rxv); end
        n_cmp++; if (t_done != 133) begin n_bad++; $display("FAIL busy_en_done_cycle got=%0d exp=133", t_done); end
    endtask

    task automatic test_reset_mid_xfer();
        int t_ss, t_edge, t_done, t_busy, dc;
        logic [15:0] rxv;
        @(negedge clk);
        b4.tx = 16'hA5C3;
        b4.enable = 1'b1;
        @(posedge clk);
        #1 b4.enable = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c == 50) reset = 1'b1;
        end
        @(negedge clk);
        n_cmp++; if (b4.ss_n !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ss_n got=%b exp=1", b4.ss_n); end
        n_cmp++; if (b4.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b exp=0", b4.busy); end
        n_cmp++; if (b4.done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got=%b exp=0", b4.done); end
        n_cmp++; if (b4.rx !== 16'h0) begin n_bad++; $display("FAIL rst_mid_rx got=%h exp=0000", b4.rx); end
        n_cmp++; if (b4.mosi !== 1'b0) begin n_bad++; $display("FAIL rst_mid_mosi got=%b exp=0", b4.mosi); end
        reset = 1'b0;
        @(negedge clk);
        run_xfer(16'h1234, 140, -1, t_ss, t_edge, t_done, t_busy, dc, rxv);
        n_cmp++; if (rxv !== 16'h1234) begin n_bad++; $display("FAIL rst_after_rx got=%h exp=1234", rxv); end
        n_cmp++; if (t_done != 133) begin n_bad++; $display("FAIL rst_after_done_cycle got=%0d exp=133", t_done); end
    endtask

    task automatic test_back_to_back();
        int ndone, hi;
        logic [15:0] r0, r1;
        ndone = 0; hi = 0; r0 = 'x; r1 = 'x;
        @(negedge clk);
        b1.tx = 16'h0001;
        b1.enable = 1'b1;
        @(posedge clk);
        #1 b1.tx = 16'h8000;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (b1.done === 1'b1) begin
                if (ndone == 0) r0 = b1.rx; else r1 = b1.rx;
                ndone++;
                if (ndone == 2) b1.enable = 1'b0;
            end
            if (ndone == 1 && b1.ss_n === 1'b1) hi++;
        end
        b1.enable = 1'b0;
        n_cmp++; if (ndone != 2) begin n_bad++; $display("FAIL b2b_done_count got=%0d exp=2", ndone); end
        n_cmp++; if (r0 !== 16'h0001) begin n_bad++; $display("FAIL b2b_rx0 got=%h exp=0001", r0); end
        n_cmp++; if (r1 !== 16'h8000) begin n_bad++; $display("FAIL b2b_rx1 got=%h exp=8000", r1); end
        n_cmp++; if (hi != 2) begin n_bad++; $display("FAIL b2b_ss_high_cycles got=%0d exp=2", hi); end
    endtask

    initial begin
        test_reset();
        test_mode0_timing();
        test_modes_slave();
        test_enable_while_busy();
        test_reset_mid_xfer();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
